// File: rtl/pipe_run_controller.sv
// Debug run controller: decodes UART command bytes into pipeline step/run/reset
// sequences and requests a state dump after each one.
module pipe_run_controller #(
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned PC_W         = 10
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            cmd_valid,
   input  logic [7:0]      cmd_code,
   input  logic [15:0]     cmd_arg,
   output logic            cmd_ready,
   input  logic [PC_W-1:0] pc,
   input  logic            program_finished,
   input  logic            dataSent,
   output logic            pipe_en,
   output logic            pipe_reset,
   output logic            sendSignal,
   output logic [15:0]     cycle_count,
   output logic            cmd_error,
   output logic [2:0]      state
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStep    = 3'd1,
      StRun     = 3'd2,
      StPreset  = 3'd3,
      StSend    = 3'd4,
      StWaitAck = 3'd5
   } state_e;

   localparam logic [7:0] CmdHalt  = 8'h30;
   localparam logic [7:0] CmdStep  = 8'h31;
   localparam logic [7:0] CmdRun   = 8'h32;
   localparam logic [7:0] CmdReset = 8'h33;
   localparam logic [7:0] CmdRunN  = 8'h34;
   localparam logic [7:0] CmdSetBp = 8'h35;
   localparam logic [7:0] CmdClrBp = 8'h36;
   localparam logic [3:0] RstInit  = 4'(RESET_CYCLES);

   state_e          stateQ, stateD;
   logic            pipeEnQ, pipeEnD;
   logic            pipeResetQ, pipeResetD;
   logic            sendQ, sendD;
   logic            errQ, errD;
   logic [15:0]     countQ, countD;
   logic            bpEnQ, bpEnD;
   logic [PC_W-1:0] bpAddrQ, bpAddrD;
   logic [15:0]     remainQ, remainD;
   logic            countedQ, countedD;
   logic            firstQ, firstD;
   logic [3:0]      rstCntQ, rstCntD;

   logic        accept;
   logic        haltReq;
   logic        bpHit;
   logic        runStop;
   logic [15:0] countInc;

   assign cmd_ready = (stateQ == StIdle) || (stateQ == StRun);
   assign accept    = cmd_valid && cmd_ready;
   assign haltReq   = accept && (cmd_code == CmdHalt);
   assign countInc  = (countQ == 16'hFFFF) ? countQ : countQ + 16'd1;

   // While an advance is in flight pc is stale, so the breakpoint compare waits
   // for it to settle; the first RUN cycle is exempt so a run can leave a breakpoint.
   assign bpHit   = bpEnQ && (pc == bpAddrQ) && !firstQ && !pipeEnQ;
   assign runStop = program_finished || bpHit || (countedQ && (remainQ == 16'd0)) || haltReq;

   always_comb begin
      stateD     = stateQ;
      pipeEnD    = 1'b0;
      pipeResetD = 1'b0;
      sendD      = 1'b0;
      errD       = 1'b0;
      countD     = countQ;
      bpEnD      = bpEnQ;
      bpAddrD    = bpAddrQ;
      remainD    = remainQ;
      countedD   = countedQ;
      firstD     = firstQ;
      rstCntD    = rstCntQ;

      case (stateQ)
         StIdle: begin
            if (accept) begin
               case (cmd_code)
                  CmdStep: stateD = StStep;
                  CmdRun: begin
                     stateD   = StRun;
                     countedD = 1'b0;
                     firstD   = 1'b1;
                  end
                  CmdRunN: begin
                     if (cmd_arg == 16'd0) begin
                        stateD = StSend;
                     end else begin
                        stateD   = StRun;
                        countedD = 1'b1;
                        remainD  = cmd_arg;
                        firstD   = 1'b1;
                     end
                  end
                  CmdReset: begin
                     stateD  = StPreset;
                     rstCntD = RstInit;
                  end
                  CmdSetBp: begin
                     bpEnD   = 1'b1;
                     bpAddrD = cmd_arg[PC_W-1:0];
                  end
                  CmdClrBp: bpEnD = 1'b0;
                  default:  errD  = 1'b1;
               endcase
            end
         end
         StStep: begin
            if (!program_finished) begin
               pipeEnD = 1'b1;
               countD  = countInc;
            end
            stateD = StSend;
         end
         StRun: begin
            if (accept && !haltReq) begin
               errD = 1'b1;
            end
            if (runStop) begin
               stateD = StSend;
            end else if (!pipeEnQ) begin
               // One advance at a time so stop conditions see the resulting pc.
               pipeEnD = 1'b1;
               countD  = countInc;
               firstD  = 1'b0;
               if (countedQ) begin
                  remainD = remainQ - 16'd1;
               end
            end
         end
         StPreset: begin
            pipeResetD = 1'b1;
            countD     = 16'd0;
            rstCntD    = rstCntQ - 4'd1;
            if (rstCntQ == 4'd1) begin
               stateD = StSend;
            end
         end
         StSend: begin
            sendD  = 1'b1;
            stateD = StWaitAck;
         end
         StWaitAck: begin
            if (dataSent) begin
               stateD = StIdle;
            end
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ     <= StIdle;
         pipeEnQ    <= 1'b0;
         pipeResetQ <= 1'b0;
         sendQ      <= 1'b0;
         errQ       <= 1'b0;
         countQ     <= 16'd0;
         bpEnQ      <= 1'b0;
         bpAddrQ    <= '0;
         remainQ    <= 16'd0;
         countedQ   <= 1'b0;
         firstQ     <= 1'b0;
         rstCntQ    <= 4'd0;
      end else begin
         stateQ     <= stateD;
         pipeEnQ    <= pipeEnD;
         pipeResetQ <= pipeResetD;
         sendQ      <= sendD;
         errQ       <= errD;
         countQ     <= countD;
         bpEnQ      <= bpEnD;
         bpAddrQ    <= bpAddrD;
         remainQ    <= remainD;
         countedQ   <= countedD;
         firstQ     <= firstD;
         rstCntQ    <= rstCntD;
      end
   end

   assign pipe_en     = pipeEnQ;
   assign pipe_reset  = pipeResetQ;
   assign sendSignal  = sendQ;
   assign cmd_error   = errQ;
   assign cycle_count = countQ;
   assign state       = stateQ;

endmodule

// File: tb/tb_pipe_run_controller.sv
// Bench for pipe_run_controller: table of single commands with hand-computed pulse
// counts, plus sequences for halt, illegal-in-run, and asynchronous reset.
module tb_pipe_run_controller;

   localparam int unsigned PcW = 10;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           cmd_valid = 1'b0;
   logic [7:0]     cmd_code = 8'h00;
   logic [15:0]    cmd_arg = 16'h0000;
   logic           cmd_ready;
   logic [PcW-1:0] pc;
   logic           program_finished = 1'b0;
   logic           dataSent = 1'b0;
   logic           pipe_en;
   logic           pipe_reset;
   logic           sendSignal;
   logic [15:0]    cycle_count;
   logic           cmd_error;
   logic [2:0]     state;

   always #5 clock = ~clock;

   pipe_run_controller #(
      .RESET_CYCLES(2),
      .PC_W        (PcW)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_code        (cmd_code),
      .cmd_arg         (cmd_arg),
      .cmd_ready       (cmd_ready),
      .pc              (pc),
      .program_finished(program_finished),
      .dataSent        (dataSent),
      .pipe_en         (pipe_en),
      .pipe_reset      (pipe_reset),
      .sendSignal      (sendSignal),
      .cycle_count     (cycle_count),
      .cmd_error       (cmd_error),
      .state           (state)
   );

   // Pipeline model: pc advances by 4 per pipe_en, cleared by pipe_reset.
   logic [PcW-1:0] pcModel = '0;
   assign pc = pcModel;

   int enCnt = 0, rstCnt = 0, sendCnt = 0, errCnt = 0, clashCnt = 0;

   always @(posedge clock) begin
      if (pipe_en) enCnt <= enCnt + 1;
      if (pipe_reset) rstCnt <= rstCnt + 1;
      if (sendSignal) sendCnt <= sendCnt + 1;
      if (cmd_error) errCnt <= errCnt + 1;
      if (pipe_en && pipe_reset) clashCnt <= clashCnt + 1;
      if (pipe_reset) pcModel <= '0;
      else if (pipe_en) pcModel <= pcModel + 10'd4;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic sendCmd(input logic [7:0] code, input logic [15:0] arg);
      cmd_valid = 1'b1;
      cmd_code  = code;
      cmd_arg   = arg;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   // Wait for the dump request, acknowledge 5 cycles later, expect a return to IDLE.
   task automatic finishDump(input string name);
      int n = 0;
      while (sendSignal !== 1'b1 && n < 2000) begin
         tick(1);
         n++;
      end
      check({name, " sendSignal seen"}, int'(sendSignal), 1);
      check({name, " waitack state"}, int'(state), 5);
      check({name, " ready low"}, int'(cmd_ready), 0);
      tick(5);
      dataSent = 1'b1;
      tick(1);
      dataSent = 1'b0;
      tick(1);
      check({name, " idle state"}, int'(state), 0);
      check({name, " ready high"}, int'(cmd_ready), 1);
   endtask

   typedef struct {
      logic [7:0]  code;
      logic [15:0] arg;
      logic        pf;
      int          expEn;
      int          expCount;
      int          expRst;
      bit          expSend;
      int          expErr;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int e0, r0, s0, x0;

      #200_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, r0, s0, x0;

      //            code   arg       pf    en   cc   rst send err
      vecs[0]  = '{8'h31, 16'h0000, 1'b0, 1,   1,   0, 1'b1, 0};
      vecs[1]  = '{8'h34, 16'h0007, 1'b0, 7,   8,   0, 1'b1, 0};
      vecs[2]  = '{8'h34, 16'h0000, 1'b0, 0,   8,   0, 1'b1, 0};
      vecs[3]  = '{8'h30, 16'h0000, 1'b0, 0,   8,   0, 1'b0, 1};
      vecs[4]  = '{8'h7A, 16'h0000, 1'b0, 0,   8,   0, 1'b0, 1};
      vecs[5]  = '{8'h31, 16'h0000, 1'b1, 0,   8,   0, 1'b1, 0};
      vecs[6]  = '{8'h32, 16'h0000, 1'b1, 0,   8,   0, 1'b1, 0};
      vecs[7]  = '{8'h33, 16'h0000, 1'b0, 0,   0,   2, 1'b1, 0};
      vecs[8]  = '{8'h35, 16'h000C, 1'b0, 0,   0,   0, 1'b0, 0};
      vecs[9]  = '{8'h32, 16'h0000, 1'b0, 3,   3,   0, 1'b1, 0};
      vecs[10] = '{8'h32, 16'h0000, 1'b0, 256, 259, 0, 1'b1, 0};
      vecs[11] = '{8'h36, 16'h0000, 1'b0, 0,   259, 0, 1'b0, 0};
      vecs[12] = '{8'h34, 16'd300,  1'b0, 300, 559, 0, 1'b1, 0};
      vecs[13] = '{8'h35, 16'hF008, 1'b0, 0,   559, 0, 1'b0, 0};
      vecs[14] = '{8'h33, 16'h0000, 1'b0, 0,   0,   2, 1'b1, 0};
      vecs[15] = '{8'h32, 16'h0000, 1'b0, 2,   2,   0, 1'b1, 0};

      tick(2);
      check("reset pipe_en", int'(pipe_en), 0);
      check("reset pipe_reset", int'(pipe_reset), 0);
      check("reset sendSignal", int'(sendSignal), 0);
      check("reset cmd_error", int'(cmd_error), 0);
      check("reset cycle_count", int'(cycle_count), 0);
      check("reset state", int'(state), 0);
      check("reset cmd_ready", int'(cmd_ready), 1);
      reset = 1'b1;
      tick(1);

      for (int i = 0; i < 16; i++) begin
         e0 = enCnt;
         r0 = rstCnt;
         s0 = sendCnt;
         x0 = errCnt;
         program_finished = vecs[i].pf;
         sendCmd(vecs[i].code, vecs[i].arg);
         if (vecs[i].expSend) finishDump($sformatf("v%0d", i));
         else tick(4);
         program_finished = 1'b0;
         check($sformatf("v%0d pipe_en pulses", i), enCnt - e0, vecs[i].expEn);
         check($sformatf("v%0d cycle_count", i), int'(cycle_count), vecs[i].expCount);
         check($sformatf("v%0d pipe_reset cycles", i), rstCnt - r0, vecs[i].expRst);
         check($sformatf("v%0d sendSignal pulses", i), sendCnt - s0, int'(vecs[i].expSend));
         check($sformatf("v%0d cmd_error pulses", i), errCnt - x0, vecs[i].expErr);
      end

      // Run, illegal step mid-run, then halt.
      e0 = enCnt;
      x0 = errCnt;
      sendCmd(8'h32, 16'h0000);
      tick(3);
      check("halt run active", int'(state), 2);
      sendCmd(8'h31, 16'h0000);
      tick(1);
      check("run step error pulse", errCnt - x0, 1);
      check("run continues after error", int'(state), 2);
      tick(4);
      sendCmd(8'h30, 16'h0000);
      finishDump("halt");
      check("halt advanced", int'((enCnt - e0) > 2), 1);
      check("halt cycle_count", int'(cycle_count), 2 + (enCnt - e0));
      check("halt no extra error", errCnt - x0, 1);

      // Asynchronous reset mid-RUN.
      sendCmd(8'h32, 16'h0000);
      tick(4);
      reset = 1'b0;
      #1;
      check("arst run pipe_en", int'(pipe_en), 0);
      check("arst run pipe_reset", int'(pipe_reset), 0);
      check("arst run sendSignal", int'(sendSignal), 0);
      check("arst run cycle_count", int'(cycle_count), 0);
      check("arst run state", int'(state), 0);
      check("arst run cmd_ready", int'(cmd_ready), 1);
      e0 = enCnt;
      s0 = sendCnt;
      tick(3);
      check("arst run no advance", enCnt - e0, 0);
      check("arst run no send", sendCnt - s0, 0);
      reset = 1'b1;
      tick(1);
      e0 = enCnt;
      sendCmd(8'h31, 16'h0000);
      finishDump("post-arst step");
      check("post-arst step pulses", enCnt - e0, 1);
      check("post-arst cycle_count", int'(cycle_count), 1);

      // Asynchronous reset mid-PRESET.
      sendCmd(8'h33, 16'h0000);
      tick(1);
      check("preset active", int'(pipe_reset), 1);
      reset = 1'b0;
      #1;
      check("arst preset pipe_reset", int'(pipe_reset), 0);
      check("arst preset sendSignal", int'(sendSignal), 0);
      s0 = sendCnt;
      r0 = rstCnt;
      tick(3);
      reset = 1'b1;
      tick(3);
      check("arst preset no send", sendCnt - s0, 0);
      check("arst preset no reset pulse", rstCnt - r0, 0);
      check("arst preset idle", int'(state), 0);

      check("pipe_en/pipe_reset overlap cycles", clashCnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_run_controller.md
PIPE_RUN_CONTROLLER -- requirements
Module: pipe_run_controller

Interface
REQ-001 SHALL provide parameter RESET_CYCLES, default 2, cycles pipe_reset is held for a soft reset (legal range 1..15).
REQ-002 SHALL provide parameter PC_W, default 10, width of the pc and breakpoint compare.
REQ-003 SHALL have port clock  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command byte present (one-cycle pulse from the UART receive side).
REQ-006 SHALL have port cmd_code  input  8  ASCII command: 0x30 halt, 0x31 step, 0x32 run, 0x33 soft reset, 0x34 run-N, 0x35 set breakpoint, 0x36 clear breakpoint.
REQ-007 SHALL have port cmd_arg  input  16  operand for 0x34 (step count) and 0x35 (breakpoint PC in bits [PC_W-1:0]).
REQ-008 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 SHALL have port pc  input  PC_W  current IF/ID PC from the pipeline.
REQ-010 SHALL have port program_finished  input  1  end-of-program flag from the end detector.
REQ-011 SHALL have port dataSent  input  1  dump-complete acknowledge from the debug transmitter.
REQ-012 SHALL have port pipe_en  output  1  one-cycle pipeline advance enable, registered.
REQ-013 SHALL have port pipe_reset  output  1  active-high pipeline reset, registered.
REQ-014 SHALL have port sendSignal  output  1  one-cycle request to dump pipeline state, registered.
REQ-015 SHALL have port cycle_count  output  16  pipeline advances since the last reset, saturating.
REQ-016 SHALL have port cmd_error  output  1  one-cycle pulse on an unknown or illegal command.
REQ-017 SHALL have port state  output  3  current FSM state encoding, for debug.

Function
REQ-018 SHALL implement states IDLE=0, STEP=1, RUN=2, PRESET=3, SEND=4, WAIT_ACK=5.
REQ-019 SHALL drive cmd_ready=1 only in IDLE and RUN.
REQ-020 IDLE, on accepted command:
- 0x31 -> STEP
- 0x32 -> RUN with unlimited count
- 0x34 -> RUN with remaining=cmd_arg
- 0x34 with cmd_arg=0 -> SEND directly, no pipe_en
- 0x33 -> PRESET
- 0x35 -> bp_addr<=cmd_arg[PC_W-1:0], bp_en<=1, stay IDLE, no dump
- 0x36 -> bp_en<=0, stay IDLE
- 0x30 or any other code -> cmd_error pulse, stay IDLE
REQ-021 STEP: if program_finished=1, no pipe_en; else pipe_en=1 for exactly one cycle and cycle_count+1; then go to SEND.
REQ-022 RUN evaluates stop conditions each cycle before issuing an advance; any true -> SEND, no pipe_en that cycle:
- program_finished=1
- bp_en=1 and pc==bp_addr, except on the first RUN cycle, so a run started at the breakpoint advances
- counted run with remaining=0
- accepted halt command 0x30
REQ-023 RUN with no stop condition: pipe_en=1, cycle_count+1, remaining-1 if counted; pc from an advance is sampled on the following cycle.
REQ-024 RUN, non-0x30 command accepted: dropped with a cmd_error pulse; the run continues.
REQ-025 PRESET: pipe_reset=1 for exactly RESET_CYCLES cycles and cycle_count<=0; bp_en and bp_addr are retained; then go to SEND.
REQ-026 SEND: sendSignal=1 for one cycle, then go to WAIT_ACK.
REQ-027 WAIT_ACK: hold until dataSent=1, then go to IDLE the next cycle; dataSent in any other state is ignored.
REQ-028 cycle_count SHALL saturate at 0xFFFF; the step/run stop logic is unaffected by saturation.
REQ-029 pipe_en and pipe_reset SHALL never be high in the same cycle.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, pipe_en=0, pipe_reset=0, sendSignal=0, cmd_error=0, cycle_count=0, bp_en=0, bp_addr=0, remaining=0; cmd_ready=1.
REQ-031 Reset asserted mid-RUN or mid-PRESET SHALL abort immediately with no further pipe_en, pipe_reset or sendSignal; first command accepted one cycle after deassertion.

Verification
REQ-032 Reset, then cmd 0x31, then dataSent after 5 cycles -> exactly 1 pipe_en, cycle_count=1, 1 sendSignal, back to IDLE with cmd_ready=1.
REQ-033 cmd 0x34 arg=7 with program_finished=0 -> exactly 7 pipe_en pulses, cycle_count=7, then sendSignal; arg=0 -> 0 pulses, sendSignal.
REQ-034 cmd 0x35 arg=0x00C, then 0x32, pc incrementing by 4 from 0 -> run stops when pc=0x00C, pipe_en count=3; 0x32 again -> advances past 0x00C.
REQ-035 cmd 0x32, then 0x30 after 10 cycles -> run stops, sendSignal; 0x31 during RUN -> cmd_error pulse, run continues.
REQ-036 cmd 0x33 with RESET_CYCLES=2 -> pipe_reset high exactly 2 cycles, cycle_count=0, breakpoint still active; reset=0 mid-RUN -> all outputs 0 immediately.
